// File: rtl/ps2_host_pkg.sv
// Shared PS/2 host types: error codes, controller states, cycle conversion.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package ps2_host_pkg;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_PARITY   = 3'd1,
        ERR_FRAME    = 3'd2,
        ERR_OVERFLOW = 3'd3,
        ERR_TIMEOUT  = 3'd4,
        ERR_NACK     = 3'd5
    } ps2_err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX_INHIBIT,
        ST_TX_REQ,
        ST_TX_BITS,
        ST_TX_ACK,
        ST_TX_WAIT
    } ps2_state_t;

    // Whole clock cycles in a number of microseconds.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Generic first-word-fall-through FIFO with full/empty flags.
// Latency: a write is visible at rd_data_o the cycle after it is taken.
// Backpressure: writes are dropped when full unless a read happens in the same cycle.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pop is taken first, so a full FIFO can accept a push in the same cycle.
    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are masked by empty_o so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ps2_host.sv
// Bidirectional PS/2 host: RX frames into a FWFT FIFO, TX bytes with inhibit/RTS/ack.
// Latency: pin to fall strobe 2 + FILTER_CYCLES; rx_valid_o 1 cycle after the stop-bit fall.
// Backpressure: RX bytes dropped with OVERFLOW when FIFO full; tx_ready_o low while busy.
module ps2_host
    import ps2_host_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned INHIBIT_US     = 100,
    parameter int unsigned REQ_TIMEOUT_US = 15000,
    parameter int unsigned BIT_TIMEOUT_US = 2000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    inout  wire        ps2_clk_io,
    inout  wire        ps2_data_io,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       err_o,
    output logic [2:0] err_code_o
);

    localparam int unsigned INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned REQ_CYC = us_to_cycles(CLK_HZ, REQ_TIMEOUT_US);
    localparam int unsigned BIT_CYC = us_to_cycles(CLK_HZ, BIT_TIMEOUT_US);
    localparam int unsigned MAX_RB  = (REQ_CYC > BIT_CYC) ? REQ_CYC : BIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_RB > INH_CYC) ? MAX_RB : INH_CYC;
    localparam int          TMR_W   = $clog2(MAX_CYC + 1);
    localparam int          FLT_W   = $clog2(FILTER_CYCLES + 1);

    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INH_CYC - 1);
    localparam logic [TMR_W-1:0] REQ_LAST = TMR_W'(REQ_CYC - 1);
    localparam logic [TMR_W-1:0] BIT_LAST = TMR_W'(BIT_CYC - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

    // Line index 0 is the PS/2 clock, index 1 is PS/2 data.
    logic [1:0]            sync1_q, sync1_d, sync2_q;
    logic [1:0]            filt_q, filt_d;
    logic [1:0][FLT_W-1:0] fcnt_q, fcnt_d;
    logic                  clk_f, data_f, clk_fall;

    ps2_state_t       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       rx_sr_q, rx_sr_d;
    logic [9:0]       tx_sr_q, tx_sr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             drv_clk_q, drv_clk_d;
    logic             drv_data_q, drv_data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    ps2_err_t         err_code_q, err_code_d;
    logic             push, pop, tmo, start_rx;
    logic             fifo_full, fifo_empty;
    logic [10:0]      frame;

    // Open-drain pads: only ever pull low or release.
    assign ps2_clk_io  = drv_clk_q  ? 1'b0 : 1'bz;
    assign ps2_data_io = drv_data_q ? 1'b0 : 1'bz;

    assign sync1_d  = {ps2_data_io, ps2_clk_io};
    assign clk_f    = filt_q[0];
    assign data_f   = filt_q[1];
    assign clk_fall = filt_q[0] && !filt_d[0];
    assign frame    = {data_f, rx_sr_q};
    assign pop      = rx_valid_o && rx_ready_i;

    // Glitch filter: a new level is accepted after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FLT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FLT_W'(1);
                end
            end
        end
    end

    // Next-state logic for receive, transmit handshake and timeouts.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        timer_d    = timer_q + TMR_W'(1);
        drv_clk_d  = drv_clk_q;
        drv_data_d = drv_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        push       = 1'b0;
        tmo        = 1'b0;
        start_rx   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (clk_fall && !data_f) begin
                    start_rx  = 1'b1;
                    state_d   = ST_RX;
                    bit_cnt_d = 4'd1;
                    rx_sr_d   = {data_f, rx_sr_q[9:1]};
                end else if (tx_valid_i) begin
                    tx_sr_d   = {1'b1, ~^tx_data_i, tx_data_i};
                    drv_clk_d = 1'b1;
                    state_d   = ST_TX_INHIBIT;
                end
            end
            ST_RX: begin
                if (clk_fall) begin
                    timer_d   = '0;
                    rx_sr_d   = {data_f, rx_sr_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = ST_IDLE;
                        if (frame[0] || !frame[10]) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_FRAME;
                        end else if (!(^frame[9:1])) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PARITY;
                        end else if (fifo_full && !pop) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVERFLOW;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end else if (timer_q == BIT_LAST) begin
                    tmo = 1'b1;
                end
            end
            ST_TX_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    timer_d    = '0;
                    drv_clk_d  = 1'b0;
                    drv_data_d = 1'b1;
                    state_d    = ST_TX_REQ;
                end
            end
            ST_TX_REQ, ST_TX_BITS: begin
                if (clk_fall) begin
                    timer_d    = '0;
                    drv_data_d = !tx_sr_q[0];
                    tx_sr_d    = {1'b1, tx_sr_q[9:1]};
                    bit_cnt_d  = (state_q == ST_TX_REQ) ? 4'd1 : bit_cnt_q + 4'd1;
                    if (state_q == ST_TX_REQ) begin
                        state_d = ST_TX_BITS;
                    end else if (bit_cnt_q == 4'd9) begin
                        state_d = ST_TX_ACK;
                    end
                end else if (timer_q == ((state_q == ST_TX_REQ) ? REQ_LAST : BIT_LAST)) begin
                    tmo = 1'b1;
                end
            end
            ST_TX_ACK: begin
                if (clk_fall) begin
                    timer_d = '0;
                    if (!data_f) begin
                        state_d = ST_TX_WAIT;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NACK;
                        state_d    = ST_IDLE;
                    end
                end else if (timer_q == BIT_LAST) begin
                    tmo = 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (clk_f && data_f) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == BIT_LAST) begin
                    tmo = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo) begin
            state_d    = ST_IDLE;
            drv_clk_d  = 1'b0;
            drv_data_d = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    // State registers; reset releases both pads immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            timer_q    <= '0;
            drv_clk_q  <= 1'b0;
            drv_data_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            timer_q    <= timer_d;
            drv_clk_q  <= drv_clk_d;
            drv_data_q <= drv_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (int'(FIFO_DEPTH))
    ) u_rx_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (push),
        .wr_data_i (frame[8:1]),
        .rd_en_i   (pop),
        .rd_data_o (rx_data_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rx_valid_o = !fifo_empty;
    assign tx_ready_o = (state_q == ST_IDLE) && !start_rx;
    assign tx_done_o  = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: a behavioural PS/2 device on pulled-up open-drain lines.
// Inputs change and outputs are sampled on the falling clock edge.
// All expected values are hand-derived constants.
module tb_ps2_host;

    localparam int F       = 8;     // FILTER_CYCLES
    localparam int HALF    = 40;    // device half bit period in cycles
    localparam int INH_CYC = 200;   // 100 us at 2 MHz
    localparam int BIT_CYC = 4000;  // 2000 us at 2 MHz

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk_lo = 1'b0;
    logic       dev_data_lo = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, tx_ready_o, tx_done_o, err_o;
    logic [2:0] err_code_o;
    wire        ps2_clk, ps2_data;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int n, e0, d0;
    logic [9:0] got;

    assign ps2_clk  = dev_clk_lo  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_lo ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    always #5 clk = ~clk;

    ps2_host #(.CLK_HZ(2_000_000)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ps2_clk_io  (ps2_clk),
        .ps2_data_io (ps2_data),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready_o),
        .tx_done_o   (tx_done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always @(negedge clk) begin
        if (err_o)     err_cnt  <= err_cnt + 1;
        if (tx_done_o) done_cnt <= done_cnt + 1;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic dev_bit(input logic b);
        dev_data_lo = ~b;
        cyc(HALF);
        dev_clk_lo = 1'b1;
        cyc(HALF);
        dev_clk_lo = 1'b0;
    endtask

    // Sends bits 0..9, then drives bit 10 and pulls clk low (last fall just driven).
    task automatic frame_head(input logic [10:0] f);
        for (int i = 0; i < 10; i++) dev_bit(f[i]);
        dev_data_lo = ~f[10];
        cyc(HALF);
        dev_clk_lo = 1'b1;
    endtask

    task automatic frame_tail();
        cyc(HALF);
        dev_clk_lo = 1'b0;
        cyc(HALF);
        dev_data_lo = 1'b0;
        cyc(HALF);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic wait_clk_release(output int cnt);
        cnt = 0;
        while (ps2_clk !== 1'b1 && cnt < 2000) begin
            cnt++;
            cyc(1);
        end
    endtask

    // Device side of a host transmission: 10 clocked bits, then the ack clock.
    task automatic dev_tx(input logic pull_ack, output logic [9:0] bits);
        for (int k = 0; k < 10; k++) begin
            cyc(HALF);
            dev_clk_lo = 1'b1;
            cyc(HALF);
            dev_clk_lo = 1'b0;
            bits[k] = ps2_data;
        end
        cyc(HALF / 2);
        dev_data_lo = pull_ack;
        cyc(HALF / 2);
        dev_clk_lo = 1'b1;
        cyc(HALF);
        dev_clk_lo = 1'b0;
        dev_data_lo = 1'b0;
        cyc(HALF);
    endtask

    initial begin
        // Reset state
        cyc(5);
        check("rst_clk_released", ps2_clk, 1);
        check("rst_data_released", ps2_data, 1);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_tx_done", tx_done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_err_code", err_code_o, 0);
        rst_n = 1'b1;
        cyc(5);

        // Good 0xAA frame, exact valid latency
        frame_head(mk_frame(8'hAA, 1'b0, 1'b0));
        cyc(F + 1);
        check("rx_aa_not_early", rx_valid_o, 0);
        cyc(1);
        check("rx_aa_valid", rx_valid_o, 1);
        check("rx_aa_data", rx_data_o, 8'hAA);
        frame_tail();
        check("rx_aa_no_err", err_cnt, 0);
        pop_one();
        check("rx_aa_popped", rx_valid_o, 0);

        // Parity error
        frame_head(mk_frame(8'hAA, 1'b1, 1'b0));
        cyc(F + 2);
        check("par_pulse", err_o, 1);
        check("par_code", err_code_o, 1);
        check("par_no_push", rx_valid_o, 0);
        frame_tail();
        check("par_code_held", err_code_o, 1);

        // Stop-bit error
        frame_head(mk_frame(8'h3C, 1'b0, 1'b1));
        cyc(F + 2);
        check("frame_pulse", err_o, 1);
        check("frame_code", err_code_o, 2);
        check("frame_no_push", rx_valid_o, 0);
        frame_tail();

        // Overflow on the 9th frame, then drain in order
        for (int i = 1; i <= 8; i++) begin
            frame_head(mk_frame(8'(i), 1'b0, 1'b0));
            frame_tail();
        end
        check("ovf_head", rx_data_o, 8'h01);
        e0 = err_cnt;
        frame_head(mk_frame(8'h09, 1'b0, 1'b0));
        cyc(F + 2);
        check("ovf_pulse", err_o, 1);
        check("ovf_code", err_code_o, 3);
        frame_tail();
        check("ovf_one_err", err_cnt - e0, 1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_pop_data", rx_data_o, 32'(i));
            pop_one();
        end
        check("ovf_drained", rx_valid_o, 0);

        // Transmit 0xFF with ack
        e0 = err_cnt;
        check("tx_ready_idle", tx_ready_o, 1);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        check("tx_ready_drop", tx_ready_o, 0);
        wait_clk_release(n);
        check("tx_inhibit_cycles", n, INH_CYC);
        check("tx_rts_data_low", ps2_data, 0);
        dev_tx(1'b1, got);
        check("tx_ff_bits", got[7:0], 8'hFF);
        check("tx_ff_parity", got[8], 1);
        check("tx_ff_stop", got[9], 1);
        cyc(30);
        check("tx_done_once", done_cnt, 1);
        check("tx_ready_back", tx_ready_o, 1);
        check("tx_no_err", err_cnt - e0, 0);

        // RX timeout after 4 falls, then a good 0x55
        dev_bit(1'b0);
        dev_bit(1'b1);
        dev_bit(1'b0);
        dev_data_lo = 1'b0;
        cyc(HALF);
        dev_clk_lo = 1'b1;
        cyc(F + BIT_CYC + 1);
        check("tmo_not_early", err_o, 0);
        cyc(1);
        check("tmo_pulse", err_o, 1);
        check("tmo_code", err_code_o, 4);
        dev_clk_lo = 1'b0;
        cyc(HALF);
        frame_head(mk_frame(8'h55, 1'b0, 1'b0));
        frame_tail();
        check("tmo_next_valid", rx_valid_o, 1);
        check("tmo_next_data", rx_data_o, 8'h55);
        pop_one();

        // Reset asserted during TX_BITS
        tx_data = 8'h00;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        wait_clk_release(n);
        check("rst_tx_rts_seen", n, INH_CYC);
        for (int k = 0; k < 3; k++) begin
            cyc(HALF);
            dev_clk_lo = 1'b1;
            cyc(HALF);
            dev_clk_lo = 1'b0;
        end
        check("rst_tx_data_driven", ps2_data, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_clk", ps2_clk, 1);
        check("rst_async_data", ps2_data, 1);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("rst_tx_ready", tx_ready_o, 1);

        // NACK from device
        e0 = err_cnt;
        d0 = done_cnt;
        tx_data = 8'h12;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        wait_clk_release(n);
        check("nack_rts_seen", n, INH_CYC);
        dev_tx(1'b0, got);
        check("nack_bits", got[7:0], 8'h12);
        check("nack_parity", got[8], 1);
        cyc(30);
        check("nack_one_err", err_cnt - e0, 1);
        check("nack_code", err_code_o, 5);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_ready", tx_ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
